ps2_rx_ctrl: RTL
================

Name: ps2_rx_ctrl

Overview:
Receive controller for the keyboard serial front end. It sequences frame capture from the raw serial clock/data lines and checks start, parity and stop bits. It also supervises each frame with a watchdog and hands validated 8-bit scan codes to downstream logic over a valid/ack handshake. It sits between the board pins and the scan-code consumer, replacing free-running capture on the serial clock with a single-clock-domain sequencer.

Parameters:
TIMEOUT_CYC, 5000, max CLK cycles allowed between two sample strobes inside a frame (100 us at 50 MHz)
FILTER_LEN, 4, consecutive identical synchronised SCLK samples required before the filtered level changes
CNT_W, 13, width of the timeout counter; must hold TIMEOUT_CYC

Ports:
CLK  input  1  system clock; every register is clocked on its rising edge
RST  input  1  synchronous reset, active-high
SCLK  input  1  asynchronous serial clock from the pin; idles high
SDATA  input  1  asynchronous serial data from the pin; idles high
CODE_ACK  input  1  consumer accepts CODE; sampled only while NEW_CODE=1
CODE  output  8  last accepted scan code
NEW_CODE  output  1  CODE valid, held until acknowledged
ERR  output  1  one-cycle pulse on a rejected or aborted frame
ERR_CODE  output  2  cause of the last error: 01 framing (start or stop), 10 parity, 11 timeout; holds value until the next error
OVERRUN  output  1  a good frame was dropped because NEW_CODE was still pending
BUSY  output  1  high while a frame is in progress (RECV or CHECK)

Behaviour:
- Reset: synchronous and active-high. CODE=0, NEW_CODE=0, ERR=0, ERR_CODE=00, OVERRUN=0, BUSY=0. FSM=IDLE; bit and timeout counters 0; sync flops and filtered SCLK = 1. A partial frame in progress at reset is discarded.
- Input conditioning: 2-flop synchroniser on SCLK and on SDATA. The filtered SCLK level toggles only after FILTER_LEN consecutive synchronised samples differ from it.
- Sample strobe: one-cycle pulse on the 1->0 transition of filtered SCLK. On the strobe cycle, the synchronised SDATA is the sampled bit.
- FSM states: IDLE, RECV, CHECK.
- IDLE:
  - Strobe with bit=0 (start bit): go to RECV, bit_cnt=1, timeout counter cleared.
  - Strobe with bit=1: ignored, no error.
- RECV:
  - Each strobe shifts the bit in and increments bit_cnt. Bits 1-8 are data, LSB first; bit 9 is parity; bit 10 is stop.
  - The strobe that captures bit 10 moves the FSM to CHECK.
  - The timeout counter increments every cycle without a strobe and clears on each strobe. When it reaches TIMEOUT_CYC: ERR pulse, ERR_CODE=11, go to IDLE, partial data discarded.
- CHECK (exactly one cycle, then IDLE):
  - Odd parity: XOR(data[7:0], parity) must be 1. Stop must be 1.
  - Stop bad: error 01. Framing takes priority over parity when both are bad.
  - Else parity bad: error 10.
  - Else the frame is good.
- Latency: stop strobe at cycle t, CHECK at t+1. At t+2, CODE/NEW_CODE update, or ERR pulses with ERR_CODE updated.
- Handshake:
  - NEW_CODE stays 1 until CODE_ACK=1 is sampled while NEW_CODE=1; it clears the next cycle. CODE is stable while NEW_CODE=1.
  - CODE_ACK while NEW_CODE=0 is ignored.
- Good frame while NEW_CODE=1 with no ACK in the same cycle: CODE is kept, the new code is dropped, OVERRUN=1.
- Good frame in the same cycle as an ACK: the new code is loaded, NEW_CODE stays 1, no overrun.
- OVERRUN is sticky; it clears on the cycle NEW_CODE clears, or on RST.
- Error frames never touch CODE, NEW_CODE or OVERRUN.
- BUSY = (state != IDLE).

Test Plan:
All frames use a 20-CLK half-period (20 CLK low, 20 CLK high) per bit; FILTER_LEN=4, TIMEOUT_CYC=5000.
1. Frame 0x1C (start 0, data LSB first 0,0,1,1,1,0,0,0, parity 0, stop 1) -> NEW_CODE=1 two cycles after the stop strobe, CODE=0x1C, ERR=0. Pulse CODE_ACK -> NEW_CODE=0 the next cycle.
2. 0x1C with parity=1 -> one-cycle ERR, ERR_CODE=10, NEW_CODE stays 0. 0x1C with stop=0 -> ERR_CODE=01. Both bad -> ERR_CODE=01.
3. Send start plus 4 data bits, then hold SCLK high for 5000 CLK -> ERR pulse, ERR_CODE=11, BUSY=0. Next frame 0xF0 (parity 1) -> CODE=0xF0.
4. 0x1C then 0x32 (parity 0) with no ACK -> CODE stays 0x1C, OVERRUN=1. ACK -> NEW_CODE=0 and OVERRUN=0 the next cycle.
5. ACK asserted on the exact cycle a second good frame completes -> CODE=0x32, NEW_CODE stays 1, OVERRUN=0.
6. 2-CLK low glitch on idle SCLK -> no strobe, BUSY=0. RST asserted after bit 6 of a frame -> all outputs 0; the following 0x1C frame decodes correctly.

Source files
------------

// File: rtl/ps2_rx_ctrl_if.sv
// Scan-code handoff bundle between the PS/2 receive controller and its consumer.
// The controller drives the code, status and error fields; the consumer returns CODE_ACK.
interface ps2_rx_ctrl_if;
    logic [7:0] CODE;
    logic       NEW_CODE;
    logic       CODE_ACK;
    logic       ERR;
    logic [1:0] ERR_CODE;
    logic       OVERRUN;
    logic       BUSY;

    modport master (
        output CODE, NEW_CODE, ERR, ERR_CODE, OVERRUN, BUSY,
        input  CODE_ACK
    );

    modport slave (
        input  CODE, NEW_CODE, ERR, ERR_CODE, OVERRUN, BUSY,
        output CODE_ACK
    );
endinterface

// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive sequencer: synchronises and deglitches SCLK/SDATA, captures 11-bit frames,
// validates start/parity/stop, watches for stalled frames and hands codes over valid/ack.
//
//   state | meaning
//   IDLE  | waiting for a start bit (strobe with SDATA=0)
//   RECV  | shifting data, parity and stop bits; timeout watchdog armed
//   CHECK | one-cycle validation of the captured frame
module ps2_rx_ctrl #(
    parameter int TIMEOUT_CYC = 5000,
    parameter int FILTER_LEN  = 4,
    parameter int CNT_W       = 13
) (
    input  logic CLK,
    input  logic RST,
    input  logic SCLK,
    input  logic SDATA,
    ps2_rx_ctrl_if.master rx
);

    localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FW-1:0]    FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t state, state_nxt;

    logic          sclk_s1, sclk_s2, sdata_s1, sdata_s2;
    logic          sclk_filt, strobe;
    logic [FW-1:0] filt_cnt;

    logic [3:0]       bit_cnt;
    logic [9:0]       shreg;
    logic [CNT_W-1:0] tmo_cnt;

    logic       err_set, frame_good;
    logic [1:0] err_cause;

    logic [7:0] code_q;
    logic       new_code_q, err_q, overrun_q;
    logic [1:0] err_code_q;
    logic       ack_take;

    // Strobe is registered alongside the filtered level, so it is high on the
    // first cycle the filtered SCLK reads low.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sclk_s1   <= 1'b1;
            sclk_s2   <= 1'b1;
            sdata_s1  <= 1'b1;
            sdata_s2  <= 1'b1;
            sclk_filt <= 1'b1;
            filt_cnt  <= '0;
            strobe    <= 1'b0;
        end else begin
            sclk_s1  <= SCLK;
            sclk_s2  <= sclk_s1;
            sdata_s1 <= SDATA;
            sdata_s2 <= sdata_s1;
            strobe   <= 1'b0;
            if (sclk_s2 != sclk_filt) begin
                if (filt_cnt == FILT_LAST) begin
                    sclk_filt <= sclk_s2;
                    filt_cnt  <= '0;
                    strobe    <= sclk_filt;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        err_set    = 1'b0;
        err_cause  = 2'b00;
        frame_good = 1'b0;
        case (state)
            IDLE: begin
                if (strobe && !sdata_s2) state_nxt = RECV;
            end
            RECV: begin
                if (strobe) begin
                    if (bit_cnt == 4'd10) state_nxt = CHECK;
                end else if (tmo_cnt == TMO_LIMIT) begin
                    state_nxt = IDLE;
                    err_set   = 1'b1;
                    err_cause = 2'b11;
                end
            end
            CHECK: begin
                state_nxt = IDLE;
                if (!shreg[9]) begin
                    err_set   = 1'b1;
                    err_cause = 2'b01;
                end else if (!(^shreg[8:0])) begin
                    err_set   = 1'b1;
                    err_cause = 2'b10;
                end else begin
                    frame_good = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // shreg fills from the top: after ten shifts [7:0]=data, [8]=parity, [9]=stop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt <= '0;
            shreg   <= '0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    shreg   <= '0;
                    bit_cnt <= (strobe && !sdata_s2) ? 4'd1 : 4'd0;
                end
                RECV: begin
                    if (strobe) begin
                        shreg   <= {sdata_s2, shreg[9:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    bit_cnt <= '0;
                    tmo_cnt <= '0;
                end
            endcase
        end
    end

    assign ack_take = new_code_q && rx.CODE_ACK;

    always_ff @(posedge CLK) begin
        if (RST) begin
            code_q     <= '0;
            new_code_q <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            overrun_q  <= 1'b0;
        end else begin
            err_q <= err_set;
            if (err_set) err_code_q <= err_cause;
            if (frame_good) begin
                if (!new_code_q || ack_take) begin
                    code_q     <= shreg[7:0];
                    new_code_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (ack_take) begin
                new_code_q <= 1'b0;
                overrun_q  <= 1'b0;
            end
        end
    end

    assign rx.CODE     = code_q;
    assign rx.NEW_CODE = new_code_q;
    assign rx.ERR      = err_q;
    assign rx.ERR_CODE = err_code_q;
    assign rx.OVERRUN  = overrun_q;
    assign rx.BUSY     = (state != IDLE);

endmodule
